// File: rtl/gray_nbits.sv
// Up/down Gray-code counter with synchronous load and registered wrap pulse.
// Define GRAY_BIN_OUT_EN to add the registered binary count output bin_out.
module gray_nbits #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] gray_out,
`ifdef GRAY_BIN_OUT_EN
    output logic [WIDTH-1:0] bin_out,
`endif
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;

    // Binary equivalent of a Gray word: running XOR from the MSB down.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d = gray2bin(load_val);
        end else if (clk_en) begin
            if (up_dn) begin
                bin_d  = bin_q + ONE;
                wrap_d = (bin_q == '1);
            end else begin
                bin_d  = bin_q - ONE;
                wrap_d = (bin_q == '0);
            end
        end
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign gray_out = gray_q;
    assign wrap     = wrap_q;
`ifdef GRAY_BIN_OUT_EN
    assign bin_out  = bin_q;
`endif

endmodule

// File: tb/tb_gray_nbits.sv
// Directed self-checking bench for gray_nbits at WIDTH=4.
// Checks bin_out as well when built with GRAY_BIN_OUT_EN.
module tb_gray_nbits;

    logic       clk = 1'b0;
    logic       reset;
    logic       clk_en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] gray_out;
    logic       wrap;
`ifdef GRAY_BIN_OUT_EN
    logic [3:0] bin_out;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gray_nbits #(.WIDTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .clk_en   (clk_en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .gray_out (gray_out),
`ifdef GRAY_BIN_OUT_EN
        .bin_out  (bin_out),
`endif
        .wrap     (wrap)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [3:0] g,
                                input logic w, input logic [3:0] b);
        chk({tag, ".gray"}, 32'(gray_out), 32'(g));
        chk({tag, ".wrap"}, 32'(wrap), 32'(w));
`ifdef GRAY_BIN_OUT_EN
        chk({tag, ".bin"}, 32'(bin_out), 32'(b));
`else
        if (b > 4'd15) $display("unreachable");
`endif
    endtask

    task automatic drive(input logic r, input logic en, input logic ud,
                         input logic ld, input logic [3:0] lv);
        reset    = r;
        clk_en   = en;
        up_dn    = ud;
        load     = ld;
        load_val = lv;
    endtask

    logic [3:0] up_seq [16] = '{
        4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
        4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001,
        4'b1000, 4'b0000
    };

    initial begin
        logic [3:0] prev;

        // Reset wins over simultaneous load and enable
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'b1111);
        tick();
        expect_state("rst", 4'b0000, 1'b0, 4'd0);

        // Full up cycle with wrap on the last step
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
        prev = gray_out;
        for (int i = 0; i < 16; i++) begin
            tick();
            expect_state($sformatf("up%0d", i), up_seq[i],
                         (i == 15), 4'(i + 1));
            chk($sformatf("onebit%0d", i),
                32'($countones(prev ^ gray_out)), 32'd1);
            prev = gray_out;
        end

        // Down wrap from zero
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
        tick();
        expect_state("dn_wrap", 4'b1000, 1'b1, 4'd15);
        tick();
        expect_state("dn_next", 4'b1001, 1'b0, 4'd14);

        // Load, then count on from the loaded value
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'b1100);
        tick();
        expect_state("load", 4'b1100, 1'b0, 4'd8);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
        tick();
        expect_state("load_up", 4'b1101, 1'b0, 4'd9);

        // Loading across the boundary never pulses wrap
        drive(1'b1, 1'b0, 1'b1, 1'b1, 4'b1000);
        tick();
        expect_state("ld_max", 4'b1000, 1'b0, 4'd15);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'b0000);
        tick();
        expect_state("ld_zero", 4'b0000, 1'b0, 4'd0);

        // Count to 0110, hold five cycles, then load beats enable
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < 4; i++) tick();
        expect_state("to_0110", 4'b0110, 1'b0, 4'd4);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_state($sformatf("hold%0d", i), 4'b0110, 1'b0, 4'd4);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'b0011);
        tick();
        expect_state("ld_win", 4'b0011, 1'b0, 4'd2);

        // Direction flips take effect immediately
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
        tick();
        expect_state("flip_dn", 4'b0001, 1'b0, 4'd1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
        tick();
        expect_state("flip_up", 4'b0011, 1'b0, 4'd2);

        // Reset mid-count beats load, then resume from zero
        drive(1'b1, 1'b0, 1'b1, 1'b1, 4'b1010);
        tick();
        expect_state("at_1010", 4'b1010, 1'b0, 4'd12);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'b1111);
        tick();
        expect_state("rst_mid", 4'b0000, 1'b0, 4'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
        tick();
        expect_state("resume", 4'b0001, 1'b0, 4'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gray_nbits.md
GRAY_NBITS -- requirements
Module: gray_nbits

Interface
REQ-001 Parameter WIDTH, default 4; counter width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clk.
REQ-004 clk_en  input  1  count enable; high = advance one step per clock.
REQ-005 up_dn  input  1  direction; 1 = count up, 0 = count down.
REQ-006 load  input  1  synchronous load strobe.
REQ-007 load_val  input  WIDTH  Gray-coded value to load.
REQ-008 gray_out  output  WIDTH  registered Gray-coded count.
REQ-009 wrap  output  1  registered one-cycle pulse on count wrap-around.

Function
REQ-010 The block SHALL hold an internal WIDTH-bit binary count B; gray_out SHALL equal the registered value of B ^ (B >> 1).
REQ-011 Priority per edge SHALL be reset, then load, then clk_en, then hold.
REQ-012 On load=1, B SHALL take the binary equivalent of load_val (prefix-XOR from MSB) and gray_out SHALL show load_val on the next cycle; clk_en and up_dn are ignored that cycle.
REQ-013 On load=0 and clk_en=1, B SHALL become B+1 mod 2^WIDTH when up_dn=1, or B-1 mod 2^WIDTH when up_dn=0.
REQ-014 On load=0 and clk_en=0, B and gray_out SHALL hold; wrap SHALL be 0.
REQ-015 Latency SHALL be one clock from a sampled control input to the updated gray_out.
REQ-016 Successive enabled counts SHALL change exactly one bit of gray_out, including across wrap-around.
REQ-017 wrap SHALL be 1 for exactly the cycle in which gray_out shows the wrapped value. This occurs for an up-step from B=2^WIDTH-1 to 0, or a down-step from 0 to 2^WIDTH-1. Otherwise wrap SHALL be 0.
REQ-018 A load SHALL never assert wrap, even if it moves the count across the boundary.
REQ-019 A change of up_dn SHALL take effect on the same edge it is sampled, with no dead cycle.

Reset
REQ-020 With reset=0 at a rising edge, B, gray_out and wrap SHALL all become 0, regardless of load and clk_en.
REQ-021 A reset asserted mid-count SHALL discard the count; counting SHALL resume from 0 on the first edge with reset=1.
REQ-022 Before the first reset edge, output values SHALL be treated as unspecified.

Configuration
REQ-023 Macro GRAY_BIN_OUT_EN:
- When defined, the block SHALL add output port bin_out (WIDTH bits), which is registered, equals B, is aligned with gray_out, and resets to 0.
- When undefined, the bin_out port and its logic SHALL be absent.
- All other behaviour SHALL be identical in both builds.

Verification (WIDTH=4)
REQ-024 Reset, then clk_en=1, up_dn=1 for 16 cycles -> gray_out SHALL step 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000. wrap SHALL be 1 only on the final 0000. Each step SHALL change exactly one bit.
REQ-025 From reset, clk_en=1, up_dn=0 for 1 cycle -> gray_out=1000 with wrap=1; the next down-step -> 1001 with wrap=0.
REQ-026 load=1, load_val=1100, then clk_en=1, up_dn=1 -> gray_out=1100 then 1101. wrap SHALL stay 0. With GRAY_BIN_OUT_EN, bin_out SHALL be 8 then 9.
REQ-027 Count to 0110, drop clk_en for 5 cycles -> gray_out SHALL hold 0110 with wrap=0. load=1 together with clk_en=1 and load_val=0011 -> 0011 (load wins).
REQ-028 At gray_out=1010, drive reset=0 together with load=1 -> gray_out SHALL be 0000 next cycle. After reset=1 with clk_en=1, up_dn=1 -> 0001.
